// File: rtl/layer_scheduler.sv
// layer_scheduler: broadcasts a serial input stream to one layer of neurons, gathers their results
// and re-serialises them downstream. Define LAYER_SCHED_ARGMAX_EN for a running argmax of the results.
module layer_scheduler #(
    parameter int unsigned numNeuron = 30,
    parameter int unsigned numInput  = 784,
    parameter int unsigned dataWidth = 16
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic [dataWidth-1:0]                                  in_data,
    input  logic                                                  in_valid,
    output logic                                                  in_ready,
    output logic [dataWidth-1:0]                                  neuron_data,
    output logic                                                  neuron_valid,
    input  logic [numNeuron*dataWidth-1:0]                        neuron_out,
    input  logic [numNeuron-1:0]                                  neuron_outvalid,
    output logic [dataWidth-1:0]                                  out_data,
    output logic                                                  out_valid,
    input  logic                                                  out_ready,
    output logic                                                  out_last,
    output logic                                                  busy,
    output logic                                                  err,
    output logic [((numNeuron > 1) ? $clog2(numNeuron) : 1)-1:0]  argmax_idx,
    output logic                                                  argmax_valid
);

    localparam int unsigned IDX_W = (numNeuron > 1) ? $clog2(numNeuron) : 1;
    localparam int unsigned CNT_W = $clog2(numInput + 1);

    typedef enum logic [1:0] {FEED, WAIT, DRAIN} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_W-1:0]       in_cnt;
    logic [IDX_W-1:0]       out_idx;
    logic [numNeuron-1:0]   mask;
    logic [dataWidth-1:0]   res_buf [numNeuron];
    logic [numNeuron-1:0]   take;
    logic                   in_hs;
    logic                   out_hs;
    logic                   in_last;
    logic                   out_end;
    logic                   all_done;

    assign in_hs    = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;
    assign in_last  = (in_cnt == CNT_W'(numInput - 1));
    assign out_end  = (out_idx == IDX_W'(numNeuron - 1));
    // Only first-time strobes inside WAIT are captured; repeats and stray pulses are dropped.
    assign take     = (state == WAIT) ? (neuron_outvalid & ~mask) : '0;
    assign all_done = &(mask | neuron_outvalid);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FEED;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        busy      = (in_cnt != '0);
        case (state)
            FEED: begin
                in_ready = 1'b1;
                if (in_valid && in_last) state_nxt = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (all_done) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = res_buf[out_idx];
                out_last  = out_end;
                if (out_ready && out_end) state_nxt = FEED;
            end
            default: state_nxt = FEED;
        endcase
    end

    // Input broadcast, result bookkeeping and sticky protocol error.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_cnt       <= '0;
            out_idx      <= '0;
            mask         <= '0;
            neuron_data  <= '0;
            neuron_valid <= 1'b0;
            err          <= 1'b0;
        end else begin
            neuron_valid <= in_hs;
            if (in_hs) begin
                neuron_data <= in_data;
                in_cnt      <= in_last ? '0 : in_cnt + CNT_W'(1);
            end
            mask <= mask | take;
            if (out_hs) begin
                if (out_end) begin
                    out_idx <= '0;
                    mask    <= '0;
                end else begin
                    out_idx <= out_idx + IDX_W'(1);
                end
            end
            if ((state != WAIT) ? (|neuron_outvalid) : (|(neuron_outvalid & mask))) begin
                err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < numNeuron; i++) begin
            if (take[i]) res_buf[i] <= neuron_out[i*dataWidth +: dataWidth];
        end
    end

`ifdef LAYER_SCHED_ARGMAX_EN
    logic signed [dataWidth-1:0] max_val;
    logic [IDX_W-1:0]            max_idx;
    logic                        new_max;

    // Strict compare so a tie keeps the earlier (lower) index.
    assign new_max = (out_idx == '0) || ($signed(out_data) > max_val);

    always_ff @(posedge clk) begin
        if (rst) begin
            max_val      <= '0;
            max_idx      <= '0;
            argmax_idx   <= '0;
            argmax_valid <= 1'b0;
        end else begin
            argmax_valid <= out_hs && out_end;
            if (out_hs) begin
                if (new_max) begin
                    max_val <= $signed(out_data);
                    max_idx <= out_idx;
                end
                if (out_end) argmax_idx <= new_max ? out_idx : max_idx;
            end
        end
    end
`else
    assign argmax_idx   = '0;
    assign argmax_valid = 1'b0;
`endif

endmodule
